sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter that shares the single 32-bit SRAM controller between the MEM stage (port A) and a secondary master such as a program loader or debug/DMA engine (port B). It sits between the requesters and the SRAM controller and serialises their word transactions. It drives the controller's enable/address/data inputs and returns read data and a completion pulse to the granted requester. Port A sees the same stall-style ready it uses today, so the pipeline freeze logic is unchanged.

## Interface
- PRIORITY_MODE, 0: 0 = round-robin between A and B; 1 = fixed priority, A wins every tie.
- TIMEOUT, 1023: max cycles a grant waits for mem_ready before abort; 10-bit counter.

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- a_req / b_req  input  1  transaction request, held until matching done
- a_we / b_we  input  1  1 = write, 0 = read; stable while req high
- a_addr / b_addr  input  32  byte address; stable while req high
- a_wdata / b_wdata  input  32  write data; stable while req high
- a_rdata / b_rdata  output  32  read data, valid in done cycle and held until next completion for that port
- a_done / b_done  output  1  one-cycle completion pulse
- a_ready  output  1  !a_req | a_done; MEM-stage freeze signal
- mem_r_en / mem_w_en  output  1  to SRAM controller R_EN / W_EN
- mem_addr / mem_wdata  output  32  to controller address / data_in
- mem_rdata  input  32  from controller data_out
- mem_ready  input  1  from controller; high while an enable is asserted means completion this cycle
- busy  output  1  state != IDLE
- owner  output  1  0 = A, 1 = B; last/current grant
- timeout_err  output  1  sticky; set on any timeout, cleared only by reset

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE: with no request, stay in IDLE. With a request:
  - Pick a winner. Round-robin: on a tie, grant the port not equal to last owner. PRIORITY_MODE=1: A wins every tie.
  - Latch owner, we, addr and wdata from the winner, then go to GRANT.
- GRANT:
  - Drive mem_r_en = !we and mem_w_en = we from the latched values; mem_addr and mem_wdata come from the latched registers.
  - Increment the wait counter each cycle.
  - When mem_ready = 1: capture mem_rdata into the owner's rdata register (reads only), go to RELEASE.
  - When the counter reaches TIMEOUT: set timeout_err, leave rdata unchanged, go to RELEASE.
- RELEASE:
  - Enables low for this cycle so the controller returns to idle.
  - Pulse the owner's done.
  - Clear the counter and return to IDLE.
- A requester keeping req high after done starts a new transaction: it is arbitrated in the following IDLE cycle.
- If req drops mid-GRANT (protocol violation), the transaction still completes and done still pulses. Nothing is cancelled.
- The non-owner's req/data are ignored until the next IDLE.
- Write data is never forwarded to rdata.

## Timing
- Reset values: mem_r_en = mem_w_en = 0; mem_addr = mem_wdata = 0; a_rdata = b_rdata = 0; a_done = b_done = 0; busy = 0; owner = 1, so A wins the first round-robin tie; timeout_err = 0; state IDLE; counter 0.
- Reset is asynchronous. Asserted mid-GRANT, enables drop immediately and there is no done pulse. The SRAM controller shares the same rst.
- Latency: req seen in IDLE at cycle 0 → enable asserted in cycles 1..k, where k is the first cycle with mem_ready = 1 → done at k+1 → IDLE at k+2.
- Minimum occupancy: 3 cycles per transaction. Back-to-back from the same port runs one transaction per (k+2) cycles.
- All outputs are registered or decoded from state/latched registers. No combinational path from req to mem_*.
- The only combinational path is a_ready from a_req.
- The counter is 10 bits and saturates. TIMEOUT = 0 is illegal.

## Structure
- Shared package arm_mem_pkg holds:
  - state encoding: IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2
  - OWNER_A = 1'b0, OWNER_B = 1'b1
- One sub-module, arb2_pick: combinational two-way pick from (a_req, b_req, last owner, PRIORITY_MODE) returning grant_valid and grant_owner. The parent holds all sequential state.

## Test plan
- Single read on A at 0x100; model returns 0xDEADBEEF with mem_ready on the 3rd enable cycle → mem_r_en high 3 cycles, a_done one cycle later, a_rdata = 0xDEADBEEF, a_ready low until done.
- A and B request together, round-robin, both held for 4 transactions → grants alternate A, B, A, B; owner toggles; no port is granted twice in a row.
- Same stimulus with PRIORITY_MODE=1 → A granted for all 4; B granted only after a_req drops.
- Write on B (addr 0x40, data 0x12345678) with mem_ready immediate → mem_w_en for 1 cycle, then enables low for 1 cycle, b_done, b_rdata unchanged.
- mem_ready held 0 with TIMEOUT=8 → enable held 8 cycles, timeout_err set and sticky, done pulses, next request still served.
- rst asserted in the 2nd GRANT cycle → enables low in the same cycle, no done, busy = 0, owner = 1; normal operation after release.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, owner ids and counter width.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    localparam int CNT_W = 10;

endpackage

// File: rtl/sram_arbiter_arb2_pick.sv
// Combinational two-way winner selection for the SRAM arbiter.
module arb2_pick
    import arm_mem_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic a_req,
    input  logic b_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    // On a tie, round-robin hands the grant to whichever port did not own it last.
    always_comb begin
        grant_valid = a_req | b_req;
        grant_owner = OWNER_A;
        if (a_req && b_req) begin
            grant_owner = (PRIORITY_MODE != 0) ? OWNER_A : ~last_owner;
        end else if (b_req) begin
            grant_owner = OWNER_B;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Serialises word transactions from port A (MEM stage) and port B onto one SRAM controller.
module sram_arbiter
    import arm_mem_pkg::*;
#(
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic [31:0] a_rdata,
    output logic        a_done,
    output logic        a_ready,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic [31:0] b_rdata,
    output logic        b_done,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        owner,
    output logic        timeout_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      a_rdata_q, a_rdata_d;
    logic [31:0]      b_rdata_q, b_rdata_d;
    logic             terr_q, terr_d;
    logic             grant_valid;
    logic             grant_owner;

    arb2_pick #(
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .last_owner  (owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        terr_d    = terr_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    we_d    = (grant_owner == OWNER_B) ? b_we    : a_we;
                    addr_d  = (grant_owner == OWNER_B) ? b_addr  : a_addr;
                    wdata_d = (grant_owner == OWNER_B) ? b_wdata : a_wdata;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cnt_d = cnt_inc;
                // A completion in the same cycle as the timeout still counts as a success.
                if (mem_ready) begin
                    if (!we_q) begin
                        if (owner_q == OWNER_B) begin
                            b_rdata_d = mem_rdata;
                        end else begin
                            a_rdata_d = mem_rdata;
                        end
                    end
                    state_d = RELEASE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    terr_d  = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Owner resets to B so the first round-robin tie goes to A.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_B;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            terr_q    <= terr_d;
        end
    end

    assign mem_r_en    = (state_q == GRANT) && !we_q;
    assign mem_w_en    = (state_q == GRANT) && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign a_done      = (state_q == RELEASE) && (owner_q == OWNER_A);
    assign b_done      = (state_q == RELEASE) && (owner_q == OWNER_B);
    assign a_ready     = !a_req || a_done;
    assign busy        = (state_q != IDLE);
    assign owner       = owner_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench: round-robin and fixed-priority arbiters sharing one clock and reset.
module tb_sram_arbiter;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  lat;
        logic [31:0] rdval;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int          exp_en;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_done, b_done, a_ready;
    logic        mem_r_en, mem_w_en, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, owner, timeout_err;

    logic        p_a_req, p_b_req;
    logic [31:0] p_a_rdata, p_b_rdata;
    logic        p_a_done, p_b_done, p_a_ready;
    logic        p_mem_r_en, p_mem_w_en, p_mem_ready;
    logic [31:0] p_mem_addr, p_mem_wdata;
    logic        p_busy, p_owner, p_timeout_err;

    logic [7:0]  lat0;
    logic [7:0]  en_cnt;
    logic [31:0] rd_val;

    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[5];

    always #5 clk = ~clk;

    sram_arbiter #(.PRIORITY_MODE(0), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_done(a_done), .a_ready(a_ready),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_done(b_done),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    sram_arbiter #(.PRIORITY_MODE(1), .TIMEOUT(8)) dut_prio (
        .clk(clk), .rst(rst),
        .a_req(p_a_req), .a_we(1'b0), .a_addr(32'h0000_0010), .a_wdata(32'h0),
        .a_rdata(p_a_rdata), .a_done(p_a_done), .a_ready(p_a_ready),
        .b_req(p_b_req), .b_we(1'b0), .b_addr(32'h0000_0020), .b_wdata(32'h0),
        .b_rdata(p_b_rdata), .b_done(p_b_done),
        .mem_r_en(p_mem_r_en), .mem_w_en(p_mem_w_en), .mem_addr(p_mem_addr),
        .mem_wdata(p_mem_wdata), .mem_rdata(32'h0), .mem_ready(p_mem_ready),
        .busy(p_busy), .owner(p_owner), .timeout_err(p_timeout_err)
    );

    // Controller model: ready on the lat0-th enable cycle, never when lat0 is 0.
    assign mem_ready   = (mem_r_en || mem_w_en) && (lat0 != 8'd0) && (en_cnt == lat0 - 8'd1);
    assign mem_rdata   = rd_val;
    assign p_mem_ready = p_mem_r_en || p_mem_w_en;

    always @(posedge clk) begin
        en_cnt <= ((mem_r_en || mem_w_en) && !mem_ready) ? en_cnt + 8'd1 : 8'd0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        if (port) begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end
    endtask

    // Runs one transaction, watching the bus, a_ready and the foreign done along the way.
    task automatic run_txn(input vec_t v, output int en_cycles, output int wait_cycles,
                           output bit done_seen, output bit bus_ok, output bit ready_ok);
        logic d, other;
        en_cycles = 0; wait_cycles = 0; done_seen = 0; bus_ok = 1; ready_ok = 1;
        @(negedge clk);
        lat0   = v.lat;
        rd_val = v.rdval;
        applyStimulus(v.port, v.we, v.addr, v.wdata);
        for (int i = 0; i < 40 && !done_seen; i++) begin
            @(negedge clk);
            wait_cycles++;
            if (mem_r_en || mem_w_en) begin
                en_cycles++;
                if (mem_addr !== v.addr || mem_wdata !== v.wdata ||
                    mem_r_en !== !v.we || mem_w_en !== v.we) bus_ok = 0;
            end
            d     = v.port ? b_done : a_done;
            other = v.port ? a_done : b_done;
            if (other) bus_ok = 0;
            if (a_ready !== (v.port ? 1'b1 : a_done)) ready_ok = 0;
            if (d) begin
                done_seen = 1;
                a_req = 1'b0;
                b_req = 1'b0;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic check_txn(input string tag, input vec_t v);
        int  en_c, wait_c;
        bit  dn, bok, rok;
        run_txn(v, en_c, wait_c, dn, bok, rok);
        checkOutput({tag, "_done"}, 32'(dn), 32'd1);
        checkOutput({tag, "_en_cycles"}, 32'(en_c), 32'(v.exp_en));
        checkOutput({tag, "_latency"}, 32'(wait_c), 32'(v.exp_en + 1));
        checkOutput({tag, "_bus"}, 32'(bok), 32'd1);
        checkOutput({tag, "_a_ready"}, 32'(rok), 32'd1);
        checkOutput({tag, "_a_rdata"}, a_rdata, v.exp_a);
        checkOutput({tag, "_b_rdata"}, b_rdata, v.exp_b);
        @(negedge clk);
        checkOutput({tag, "_done_cleared"}, 32'({a_done, b_done}), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        logic        rr_exp[4];
        logic        pr_exp[5];
        vec_t        tv;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         8'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         3};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 8'd1, 32'h9999_9999, 32'hDEAD_BEEF, 32'h0,         1};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         8'd2, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0200, 32'h0BAD_F00D, 8'd1, 32'h1111_1111, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0204, 32'h0,         8'd5, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'hCAFE_F00D, 5};
        rr_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
        pr_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b0;
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
        p_a_req = 0; p_b_req = 0;
        lat0 = 8'd1; rd_val = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("rst_enables", 32'({mem_r_en, mem_w_en}), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_rdata", a_rdata | b_rdata, 32'h0);
        checkOutput("rst_done", 32'({a_done, b_done}), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd1);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_a_ready", 32'(a_ready), 32'd1);
        rst = 1'b1;

        $display("[TB] round-robin tie, both ports held for four transactions");
        @(negedge clk);
        a_addr = 32'h10; b_addr = 32'h20;
        a_req = 1'b1; b_req = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (a_done || b_done) begin
                checkOutput($sformatf("rr_grant%0d", n), 32'(b_done), 32'(rr_exp[n]));
                checkOutput($sformatf("rr_owner%0d", n), 32'(owner), 32'(rr_exp[n]));
                n++;
                if (n == 4) begin
                    a_req = 1'b0; b_req = 1'b0;
                end
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        checkOutput("rr_count", 32'(n), 32'd4);
        @(negedge clk);

        $display("[TB] fixed priority, B only after a_req drops");
        p_a_req = 1'b1; p_b_req = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && n < 5; i++) begin
            @(negedge clk);
            if (p_a_done || p_b_done) begin
                checkOutput($sformatf("prio_grant%0d", n), 32'(p_b_done), 32'(pr_exp[n]));
                n++;
                if (n == 4) p_a_req = 1'b0;
                if (n == 5) p_b_req = 1'b0;
            end
        end
        p_a_req = 1'b0; p_b_req = 1'b0;
        checkOutput("prio_count", 32'(n), 32'd5);

        for (int i = 0; i < 5; i++) begin
            check_txn($sformatf("vec%0d", i), vecs[i]);
        end

        $display("[TB] timeout with mem_ready held low");
        tv = '{1'b0, 1'b0, 32'h0000_0300, 32'h0, 8'd0, 32'h7777_7777, 32'h5A5A_5A5A, 32'hCAFE_F00D, 8};
        check_txn("tmo", tv);
        checkOutput("tmo_err_set", 32'(timeout_err), 32'd1);
        tv = '{1'b1, 1'b0, 32'h0000_0304, 32'h0, 8'd1, 32'h1357_9BDF, 32'h5A5A_5A5A, 32'h1357_9BDF, 1};
        check_txn("post_tmo", tv);
        checkOutput("tmo_err_sticky", 32'(timeout_err), 32'd1);

        $display("[TB] reset in the second grant cycle");
        @(negedge clk);
        lat0 = 8'd5; rd_val = 32'h2468_ACE0;
        applyStimulus(1'b0, 1'b0, 32'h0000_0400, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_pre_en", 32'(mem_r_en), 32'd1);
        #1 rst = 1'b0;
        #1;
        checkOutput("mid_rst_enables", 32'({mem_r_en, mem_w_en}), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_owner", 32'(owner), 32'd1);
        checkOutput("mid_rst_done", 32'({a_done, b_done}), 32'd0);
        checkOutput("mid_rst_err_clear", 32'(timeout_err), 32'd0);
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_done || b_done || busy) n++;
        end
        checkOutput("mid_rst_no_done", 32'(n), 32'd0);
        checkOutput("mid_rst_rdata", a_rdata, 32'h0);
        tv = '{1'b0, 1'b0, 32'h0000_0408, 32'h0, 8'd2, 32'h0F0F_F0F0, 32'h0F0F_F0F0, 32'h0, 2};
        check_txn("post_rst", tv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
